// File: rtl/mem_c_streamer_pkg.sv
// mem_c_streamer_pkg
// Shared constants and the controller state encoding for the MEM C streamer.
//   MC_ADDR_W     : MEM C word address width
//   MC_DATA_W     : MEM C word width
//   MC_N_WORDS    : words streamed per run
//   MC_FIFO_DEPTH : output FIFO entries (minimum 2 for bubble-free streaming)
package mem_c_streamer_pkg;

    localparam int MC_ADDR_W     = 12;
    localparam int MC_DATA_W     = 22;
    localparam int MC_N_WORDS    = 4096;
    localparam int MC_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_c_streamer_if.sv
// mem_c_streamer_if
// Bundles the MEM C read port and the valid/ready output stream.
//   mem_addr/mem_nce/mem_nwrt : read request towards MEM C (nce active low)
//   mem_q                     : MEM C read data, one cycle after the request
//   out_valid/out_ready       : stream handshake
//   out_data/out_last         : stream payload, last marks the final word
// Modports: master = streamer side, slave = memory/sink side.
interface mem_c_streamer_if
    import mem_c_streamer_pkg::*;
#(
    parameter int ADDR_W = MC_ADDR_W,
    parameter int DATA_W = MC_DATA_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_nce;
    logic              mem_nwrt;
    logic [DATA_W-1:0] mem_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output mem_addr, mem_nce, mem_nwrt, out_valid, out_data, out_last,
        input  mem_q, out_ready
    );

    modport slave (
        input  mem_addr, mem_nce, mem_nwrt, out_valid, out_data, out_last,
        output mem_q, out_ready
    );
endinterface

// File: rtl/mem_c_streamer_stream_fifo.sv
// stream_fifo
// Small synchronous FIFO; storage is a plain array, head is read
// combinationally so the stream can present it in the same cycle.
//   clk, rstn : clock, synchronous active-low reset (pointers/count only)
//   push_i    : write data_i this cycle (caller guarantees not full)
//   pop_i     : drop head this cycle (caller guarantees not empty)
//   head_o    : current head entry
//   count_o   : number of stored entries
module stream_fifo #(
    parameter int  WIDTH = 22,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) buf_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = buf_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_c_streamer.sv
// mem_c_streamer
// Reads MEM C words 0..N_WORDS-1 in order and streams them out over
// valid/ready, then pulses done. checksum accumulates every accepted word.
//   clk, rstn : clock, synchronous active-low reset
//   start     : begins a run when sampled high in IDLE
//   busy      : high while a run is in progress (including the done cycle)
//   done      : one-cycle end-of-run pulse
//   checksum  : 32-bit wrapping sum of accepted words, held until next start
//   bus       : MEM C read port and output stream (master modport)
module mem_c_streamer
    import mem_c_streamer_pkg::*;
#(
    parameter int ADDR_W     = MC_ADDR_W,
    parameter int DATA_W     = MC_DATA_W,
    parameter int N_WORDS    = MC_N_WORDS,
    parameter int FIFO_DEPTH = MC_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum,
    mem_c_streamer_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] beat_q;
    logic              inflight_q;
    logic [31:0]       checksum_q;

    logic              issue;
    logic              pop;
    logic              start_run;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [OCC_W-1:0]  occupancy;

    assign start_run = (state_q == ST_IDLE) && start;
    assign pop       = bus.out_valid && bus.out_ready;

    // Slots already claimed after this cycle's pop: stored words plus the
    // read still travelling back from MEM C.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (occupancy < OCC_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (rd_ptr_q == LAST_ADDR) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once nothing is in flight and the last stored word
                // is either gone or leaving this cycle.
                if (!inflight_q && (fifo_count == CNT_W'(pop))) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (start_run) begin
                rd_ptr_q   <= '0;
                beat_q     <= '0;
                checksum_q <= '0;
            end else begin
                if (issue) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                if (pop) begin
                    beat_q     <= beat_q + ADDR_W'(1);
                    checksum_q <= checksum_q + 32'(bus.out_data);
                end
            end
        end
    end

    // A read issued in cycle t returns on mem_q during t+1 and is pushed then.
    stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (inflight_q),
        .data_i  (bus.mem_q),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = bus.out_valid ? fifo_head : '0;
    assign bus.out_last  = bus.out_valid && (beat_q == LAST_ADDR);
    assign bus.mem_addr  = rd_ptr_q;
    assign bus.mem_nce   = ~issue;
    assign bus.mem_nwrt  = 1'b1;

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_c_streamer.sv
// tb_mem_c_streamer
// Directed bench: a MEM C model answers reads one cycle later, a scoreboard
// queue holds the expected word sequence of each run and is drained by the
// output monitor on every accepted beat.
module tb_mem_c_streamer;
    import mem_c_streamer_pkg::*;

    localparam int NW = MC_N_WORDS;
    localparam int DW = MC_DATA_W;
    localparam int AW = MC_ADDR_W;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    mem_c_streamer_if bus ();

    mem_c_streamer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .N_WORDS    (NW),
        .FIFO_DEPTH (MC_FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int pattern   = 0;   // 0: word i = i, 1: all ones
    int ready_mode = 0;  // 0: ready 1, 1: toggle, 2: ready 0

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] issued_q[$];
    int            beat_cnt = 0;
    int            issue_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            first_valid_cyc = -1;
    logic [31:0]   csum_model = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // MEM C model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (!bus.mem_nce) bus.mem_q <= (pattern == 1) ? {DW{1'b1}} : DW'(bus.mem_addr);
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor / scoreboard consumer.
    initial begin
        logic          prev_valid;
        logic          prev_ready;
        logic          prev_last;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_last  = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_nce) begin
                issue_cnt++;
                issued_q.push_back(bus.mem_addr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_valid && !prev_ready && rstn) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
                check("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e);
                    check("out_last", bus.out_last, beat_cnt == NW - 1);
                    csum_model = csum_model + 32'(e);
                    beat_cnt++;
                end
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_last  = bus.out_last;
            prev_data  = bus.out_data;
        end
    end

    // Starts a run; t1 is the cyc value seen in cycle T0+1.
    task automatic launch(input int pat, output int t1);
        pattern = pat;
        exp_q.delete();
        issued_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back((pat == 1) ? {DW{1'b1}} : DW'(i));
        beat_cnt = 0;
        issue_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
        csum_model = '0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        t1 = cyc;
        check("busy_after_start", busy, 1);
        check("first_issue_nce", bus.mem_nce, 0);
        check("first_issue_addr", bus.mem_addr, 0);
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (done_cnt == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        check("busy_after_done", busy, 0);
        check("single_done", done_cnt, 1);
    endtask

    task automatic finish_run(input string name, input logic [31:0] exp_csum,
                              input bit timed, input int t1);
        int bad;
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            if (i >= issued_q.size() || issued_q[i] !== AW'(i)) bad++;
        end
        check("issue_order", bad, 0);
        check("beat_count", beat_cnt, NW);
        check("issue_count", issue_cnt, NW);
        check("scoreboard_empty", exp_q.size(), 0);
        check("checksum_const", checksum, exp_csum);
        check("checksum_model", checksum, csum_model);
        if (timed) begin
            check("first_valid_cycle", first_valid_cyc, t1 + 2);
            check("done_cycle", done_cyc, t1 + NW + 2);
        end
        $display("run %s: beats=%0d issues=%0d checksum=%08h", name, beat_cnt, issue_cnt, checksum);
    endtask

    initial begin
        int t1;
        int ic;
        int k;
        rstn  = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nce", bus.mem_nce, 1);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_checksum", checksum, 0);
        check("nwrt", bus.mem_nwrt, 1);
        $display("reset state checked");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Identity data, sink always ready.
        ready_mode = 0;
        launch(0, t1);
        wait_done(NW + 200);
        finish_run("identity_ready1", 32'h007FF800, 1'b1, t1);

        // Identity data, sink ready every other cycle.
        ready_mode = 1;
        launch(0, t1);
        wait_done(3 * NW);
        finish_run("identity_toggle", 32'h007FF800, 1'b0, t1);

        // Sink stalled: only FIFO_DEPTH reads go out, then stream resumes.
        ready_mode = 2;
        launch(0, t1);
        repeat (50) @(negedge clk);
        check("stall_issue_count", issue_cnt, MC_FIFO_DEPTH);
        check("stall_beats", beat_cnt, 0);
        for (int i = 0; i < MC_FIFO_DEPTH; i++) check("stall_issue_addr", issued_q[i], i);
        $display("stall window: issues=%0d beats=%0d", issue_cnt, beat_cnt);
        ready_mode = 0;
        wait_done(NW + 200);
        finish_run("identity_stall50", 32'h007FF800, 1'b0, t1);

        // All-ones data with a stray start during RUN.
        ready_mode = 0;
        launch(1, t1);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(NW + 200);
        finish_run("ones_extra_start", 32'hFFFFF000, 1'b1, t1);

        // Reset in the middle of the stream, then a clean rerun.
        launch(0, t1);
        k = 0;
        while (beat_cnt < 100 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("reached_beat_100", beat_cnt >= 100, 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_nce", bus.mem_nce, 1);
        check("midrst_checksum", checksum, 0);
        check("midrst_done", done, 0);
        check("midrst_last", bus.out_last, 0);
        ic = issue_cnt;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_issue", issue_cnt, ic);
        check("midrst_idle", busy, 0);
        $display("mid-run reset at beat %0d checked", beat_cnt);
        launch(0, t1);
        wait_done(NW + 200);
        finish_run("after_reset", 32'h007FF800, 1'b1, t1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
